// File: rtl/pipe_skid_buffer_if.sv
// Handshake bundle for pipe_skid_buffer: upstream valid/ready/data and downstream valid/ready/data.
// The buffer uses the slave view; the producer/consumer side uses the master view.
interface pipe_skid_buffer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: main register drives out_data, skid register catches the beat
// accepted while downstream stalls. All handshake outputs come straight from flops.
//
//   state | meaning
//   EMPTY | nothing buffered, ready for input
//   BUSY  | main holds one beat, still ready for input
//   FULL  | main and skid both hold beats, input stalled
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_skid_buffer_if.slave    bus,
    input  logic                 flush,
    output logic [1:0]           count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       count_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    always_comb begin
        state_n        = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_n   = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_n   = FULL;
                    end else if (out_fire) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_n        = BUSY;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Handshake flags are decoded from the next state so they are pure flop outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            in_ready_q  <= (state_n != FULL);
            out_valid_q <= (state_n != EMPTY);
            case (state_n)
                BUSY:    count_q <= 2'd1;
                FULL:    count_q <= 2'd2;
                default: count_q <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : bus.in_data;
            end
            if (load_skid) begin
                skid_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign count         = count_q;
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Scoreboard bench for pipe_skid_buffer: directed scenarios plus random traffic,
// checked against an occupancy/queue model of a 2-deep FIFO with flush.
module tb_pipe_skid_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] count;

    pipe_skid_buffer_if #(.WIDTH(32)) bus ();

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .flush (flush),
        .count (count)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          occ   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check handshake flags
    // against the model, then advance the model to what the next rising edge does.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic in_acc;
        logic out_acc;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, (occ < 2)});
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, (occ > 0)});
        check("count", {30'b0, count}, occ);
        if (fl) begin
            exp_q.delete();
            occ = 0;
        end else begin
            in_acc  = iv && (occ < 2);
            out_acc = ordy && (occ > 0);
            if (in_acc) exp_q.push_back(d);
            occ = occ + int'(in_acc) - int'(out_acc);
        end
    endtask

    // Monitor: every delivered beat must be the oldest outstanding accepted beat.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && !flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", bus.out_data, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_data", bus.out_data, exp);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_count", {30'b0, count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single beat
        cycle(1'b1, 32'hA5, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // streaming 0x01..0x08
        for (int i = 1; i <= 8; i++) cycle(1'b1, i, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // backpressure, then offer 0x33 while FULL and draining
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // flush from FULL with simultaneous in/out transfer requests
        cycle(1'b1, 32'h44, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 32'h66, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // asynchronous reset while FULL
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        cycle(1'b1, 32'h88, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("async_count", {30'b0, count}, 32'd0);
        exp_q.delete();
        occ = 0;
        #1 reset = 1'b0;
        cycle(1'b1, 32'h99, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 15) == 0);
        end

        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_skid_buffer.md
PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, data payload width in bits (WIDTH >= 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream has data on in_data.
REQ-005 SHALL have port: in_ready  output  1  buffer accepts data this cycle; driven directly from a flop.
REQ-006 SHALL have port: in_data  input  WIDTH  upstream payload.
REQ-007 SHALL have port: out_valid  output  1  out_data is valid.
REQ-008 SHALL have port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-009 SHALL have port: out_data  output  WIDTH  downstream payload; driven directly from the main data register.
REQ-010 SHALL have port: flush  input  1  synchronous discard of all buffered entries.
REQ-011 SHALL have port: count  output  2  occupancy, 0..2.

Function
REQ-012 SHALL implement a 2-entry buffer with a main register (feeds out_data) and a skid register, controlled by FSM states EMPTY, BUSY and FULL.
REQ-013 SHALL treat an input transfer as in_valid && in_ready, and an output transfer as out_valid && out_ready, both sampled on the same edge.
REQ-014 SHALL, in EMPTY: drive out_valid=0, in_ready=1, count=0; on input transfer load main <= in_data and go to BUSY.
REQ-015 SHALL, in BUSY: drive out_valid=1, in_ready=1, count=1.
REQ-016 SHALL, in BUSY with input transfer and output transfer: load main <= in_data and stay in BUSY.
REQ-017 SHALL, in BUSY with input transfer and no output transfer: load skid <= in_data and go to FULL.
REQ-018 SHALL, in BUSY with output transfer and no input transfer: go to EMPTY.
REQ-019 SHALL, in FULL: drive out_valid=1, in_ready=0, count=2, and ignore in_valid.
REQ-020 SHALL, in FULL on output transfer: load main <= skid and go to BUSY.
REQ-021 SHALL deliver data in strict FIFO order with no loss and no duplication.
REQ-022 SHALL produce out_valid one cycle after the first input transfer into EMPTY, with no combinational path from in_* to out_*.
REQ-023 SHALL have no combinational path from out_ready to in_ready, so that full throughput of one transfer per cycle is sustained in BUSY.
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on flush=1, go to EMPTY at the next edge regardless of in_valid/out_ready, with flush taking priority over every simultaneous transfer.
REQ-026 SHALL leave data register contents unspecified when out_valid=0; the bench shall not check out_data then.

Reset
REQ-027 SHALL, on reset assertion, immediately (asynchronously) force state EMPTY, out_valid=0, in_ready=1, count=0, and clear the main and skid registers to 0.
REQ-028 SHALL discard any buffered data when reset is asserted mid-operation, including from FULL.
REQ-029 SHALL accept the first input transfer on the first rising edge after reset deasserts.

Verification
REQ-030 Single beat: from reset, in_valid=1, in_data=0xA5 for 1 cycle, out_ready=1 -> out_valid=1 with out_data=0xA5 for exactly 1 cycle, count returns to 0.
REQ-031 Streaming: 8 beats 0x01..0x08 back-to-back, out_ready=1 throughout -> outputs 0x01..0x08 in order on consecutive cycles, in_ready stays 1.
REQ-032 Backpressure: out_ready=0, push 0x11, 0x22, 0x33 -> in_ready=0 after the 2nd beat and 0x33 is held off; release out_ready -> outputs 0x11, 0x22, 0x33 in order.
REQ-033 Simultaneous in/out in FULL: FULL holding 0x11/0x22, out_ready=1, in_valid=1 data 0x33 -> 0x33 not accepted that cycle; next states are BUSY(0x22) then BUSY(0x33).
REQ-034 Flush: FULL with flush=1, in_valid=1, out_ready=1 on the same edge -> next cycle count=0, out_valid=0, and no beat is delivered after the flush.
REQ-035 Async reset: assert reset between edges while FULL -> out_valid=0, in_ready=1, count=0 before the next edge.
